// File: rtl/vram_rect_fill.sv
// vram_rect_fill: rectangle fill engine that streams pixel writes through a single-word vram sel/wr/ack port.
// Define VRAM_FILL_CLIP_EN to clip rectangles to the framebuffer; otherwise addresses wrap linearly mod 2^24.
module vram_rect_fill #(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int COORD_W   = 12
)(
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [COORD_W-1:0] cmd_x_i,
  input  logic [COORD_W-1:0] cmd_y_i,
  input  logic [COORD_W-1:0] cmd_w_i,
  input  logic [COORD_W-1:0] cmd_h_i,
  input  logic [15:0]        cmd_color_i,
  input  logic [3:0]         cmd_mask_i,
  input  logic [23:0]        base_address_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic               vram_ack_i,
  output logic               vram_sel_o,
  output logic               vram_wr_o,
  output logic [3:0]         vram_mask_o,
  output logic [31:0]        vram_addr_o,
  output logic [15:0]        vram_data_out_o
);
  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;
  state_t r_state, w_next;
  logic [COORD_W-1:0] r_x, r_y, r_w, r_h;
  logic [15:0]        r_color;
  logic [3:0]         r_mask;
  logic [23:0]        r_base, r_row_base;
  logic [COORD_W:0]   r_cur_x, r_cur_y, r_x_end, r_y_end, w_x_end, w_y_end;
  logic               r_sel, w_empty, w_x_last, w_last;
`ifdef VRAM_FILL_CLIP_EN
  localparam logic [COORD_W:0] LP_XMAX = (COORD_W+1)'(FB_WIDTH);
  localparam logic [COORD_W:0] LP_YMAX = (COORD_W+1)'(FB_HEIGHT);
`endif
  always_comb begin
    w_x_end = {1'b0, r_x} + {1'b0, r_w};
    w_y_end = {1'b0, r_y} + {1'b0, r_h};
    w_empty = (r_w == '0) || (r_h == '0);
`ifdef VRAM_FILL_CLIP_EN
    w_x_end = (w_x_end > LP_XMAX) ? LP_XMAX : w_x_end;
    w_y_end = (w_y_end > LP_YMAX) ? LP_YMAX : w_y_end;
    w_empty = w_empty || ({1'b0, r_x} >= LP_XMAX) || ({1'b0, r_y} >= LP_YMAX);
`endif
  end
  assign w_x_last = (r_cur_x + 1'b1) >= r_x_end;
  assign w_last   = w_x_last && ((r_cur_y + 1'b1) >= r_y_end);
  always_ff @(posedge clk or negedge reset_n_i)
    if (!reset_n_i) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = cmd_valid_i ? SETUP : IDLE;
      SETUP:   w_next = w_empty ? DONE : WRITE;
      WRITE:   w_next = r_sel ? WRITE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // r_sel falls one cycle before DONE so the last write's ack is fully retired
  always_ff @(posedge clk or negedge reset_n_i)
    if (!reset_n_i) begin
      {r_x, r_y, r_w, r_h} <= '0;
      r_color    <= '0;
      r_mask     <= '0;
      r_base     <= '0;
      r_row_base <= '0;
      {r_cur_x, r_cur_y, r_x_end, r_y_end} <= '0;
      r_sel      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid_i) begin
          {r_x, r_y, r_w, r_h} <= {cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i};
          r_color <= cmd_color_i;
          r_mask  <= cmd_mask_i;
          r_base  <= base_address_i;
        end
        SETUP: begin
          r_x_end    <= w_x_end;
          r_y_end    <= w_y_end;
          r_cur_x    <= {1'b0, r_x};
          r_cur_y    <= {1'b0, r_y};
          r_row_base <= r_base + 24'(r_y) * 24'(FB_WIDTH);
          r_sel      <= !w_empty;
        end
        WRITE: if (r_sel && vram_ack_i) begin
          if (w_last) r_sel <= 1'b0;
          else if (w_x_last) begin
            r_cur_x    <= {1'b0, r_x};
            r_cur_y    <= r_cur_y + 1'b1;
            r_row_base <= r_row_base + 24'(FB_WIDTH);
          end else r_cur_x <= r_cur_x + 1'b1;
        end
        default: ;
      endcase
    end
  assign cmd_ready_o     = r_state == IDLE;
  assign busy_o          = r_state != IDLE;
  assign done_o          = r_state == DONE;
  assign vram_sel_o      = r_sel;
  assign vram_wr_o       = r_sel;
  assign vram_mask_o     = r_mask;
  assign vram_data_out_o = r_color;
  assign vram_addr_o     = {8'h00, r_row_base + 24'(r_cur_x)};
endmodule

// File: tb/tb_vram_rect_fill.sv
// tb_vram_rect_fill: scoreboard bench; expected pixel writes are queued at issue time and popped by a monitor.
module tb_vram_rect_fill;
  logic        clk = 0, reset_n_i = 1, cmd_valid_i = 0, vram_ack_i = 0;
  logic [11:0] cmd_x_i = '0, cmd_y_i = '0, cmd_w_i = '0, cmd_h_i = '0;
  logic [15:0] cmd_color_i = '0;
  logic [3:0]  cmd_mask_i = '0;
  logic [23:0] base_address_i = '0;
  logic        cmd_ready_o, busy_o, done_o, vram_sel_o, vram_wr_o;
  logic [3:0]  vram_mask_o;
  logic [31:0] vram_addr_o;
  logic [15:0] vram_data_out_o;

  vram_rect_fill dut (
    .clk(clk), .reset_n_i(reset_n_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .cmd_w_i(cmd_w_i), .cmd_h_i(cmd_h_i),
    .cmd_color_i(cmd_color_i), .cmd_mask_i(cmd_mask_i), .base_address_i(base_address_i),
    .busy_o(busy_o), .done_o(done_o), .vram_ack_i(vram_ack_i), .vram_sel_o(vram_sel_o),
    .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o), .vram_addr_o(vram_addr_o),
    .vram_data_out_o(vram_data_out_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] a; logic [15:0] d; logic [3:0] m;} wr_t;
  wr_t q[$];
  wr_t mon_e, ex;
  int checks = 0, failures = 0, cyc = 0, t_acc = 0, d0 = 0, done_cnt = 0, done_k = 0, wr_cnt = 0, n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [15:0] d, input logic [3:0] m);
    wr_t t;
    t.a = 32'(a) & 32'h00FF_FFFF;
    t.d = d;
    t.m = m;
    q.push_back(t);
  endtask

  task automatic push_rect(input int x, input int y, input int w, input int h,
                           input logic [15:0] c, input logic [3:0] m, input logic [23:0] b);
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++) begin
`ifdef VRAM_FILL_CLIP_EN
        if (x + k >= 640 || y + r >= 480) continue;
`endif
        push_wr(int'(b) + (y + r) * 640 + x + k, c, m);
      end
  endtask

  task automatic issue(input int x, input int y, input int w, input int h,
                       input logic [15:0] c, input logic [3:0] m, input logic [23:0] b);
    @(posedge clk); #1;
    cmd_x_i = 12'(x); cmd_y_i = 12'(y); cmd_w_i = 12'(w); cmd_h_i = 12'(h);
    cmd_color_i = c; cmd_mask_i = m; base_address_i = b; cmd_valid_i = 1;
    chk("ready_before_cmd", cmd_ready_o, 1);
    d0 = done_cnt;
    wr_cnt = 0;
    @(posedge clk); #1;
    cmd_valid_i = 0;
    t_acc = cyc;
  endtask

  task automatic wait_done(input int exp_k, input string nm);
    int i = 0;
    while (done_cnt == d0 && i < 300) begin @(posedge clk); i++; end
    if (done_cnt == d0) begin
      checks++; failures++;
      $display("FAIL %s_done_timeout: got no done_o expected done_o at cycle T+%0d", nm, exp_k);
    end else chk({nm, "_done_cycle"}, done_k, exp_k);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_once"}, done_cnt, d0 + 1);
    chk({nm, "_ready_back"}, cmd_ready_o, 1);
    chk({nm, "_busy_clear"}, busy_o, 0);
    chk({nm, "_all_written"}, q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every accepted write (sel && ack) is matched against the scoreboard front.
  initial forever begin
    @(negedge clk);
    if (reset_n_i) begin
      if (done_o) begin done_cnt++; done_k = cyc - t_acc + 1; end
      if (vram_sel_o) begin
        chk("wr_eq_sel", vram_wr_o, 1);
        if (vram_ack_i) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write: got write addr=%0h data=%0h expected no write", vram_addr_o, vram_data_out_o);
          end else begin
            mon_e = q.pop_front();
            chk("wr_addr", vram_addr_o, mon_e.a);
            chk("wr_data", {16'h0, vram_data_out_o}, {16'h0, mon_e.d});
            chk("wr_mask", {28'h0, vram_mask_o}, {28'h0, mon_e.m});
            wr_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 reset_n_i = 0;
    @(negedge clk);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_sel", vram_sel_o, 0);
    chk("rst_wr", vram_wr_o, 0);
    chk("rst_addr", vram_addr_o, 0);
    chk("rst_data_mask", {vram_data_out_o, vram_mask_o}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1;
    vram_ack_i = 1;

    push_wr(641, 16'h0F00, 4'hF); push_wr(642, 16'h0F00, 4'hF);
    push_wr(1281, 16'h0F00, 4'hF); push_wr(1282, 16'h0F00, 4'hF);
    issue(1, 1, 2, 2, 16'h0F00, 4'hF, 24'h0);
    wait_done(7, "t1");

    issue(3, 3, 0, 5, 16'h1111, 4'hF, 24'h0);
    chk("t2_busy_T1", busy_o, 1);
    chk("t2_sel_T1", vram_sel_o, 0);
    @(posedge clk); #1;
    chk("t2_busy_T2", busy_o, 1);
    chk("t2_done_T2", done_o, 1);
    @(posedge clk); #1;
    chk("t2_busy_T3", busy_o, 0);
    wait_done(2, "t2");

`ifdef VRAM_FILL_CLIP_EN
    push_wr(638, 16'hFFFF, 4'hF); push_wr(639, 16'hFFFF, 4'hF);
`else
    for (int i = 0; i < 10; i++) push_wr(638 + i, 16'hFFFF, 4'hF);
`endif
    n = q.size();
    issue(638, 0, 10, 1, 16'hFFFF, 4'hF, 24'h0);
    wait_done(3 + n, "t3");

    push_rect(10, 2, 3, 1, 16'hABCD, 4'h5, 24'h100);
    issue(10, 2, 3, 1, 16'hABCD, 4'h5, 24'h100);
    for (int g = 0; g < 50 && wr_cnt < 1; g++) @(posedge clk);
    #1 vram_ack_i = 0;
    ex = q[0];
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall_sel", vram_sel_o, 1);
      chk("t4_stall_addr", vram_addr_o, ex.a);
      chk("t4_stall_data", {16'h0, vram_data_out_o}, {16'h0, ex.d});
      chk("t4_stall_mask", {28'h0, vram_mask_o}, {28'h0, ex.m});
    end
    @(posedge clk); #1 vram_ack_i = 1;
    wait_done(11, "t4");

    push_rect(2, 3, 4, 2, 16'h1234, 4'hF, 24'h200);
    issue(2, 3, 4, 2, 16'h1234, 4'hF, 24'h200);
    @(posedge clk); #1;
    cmd_x_i = 12'd50; cmd_y_i = 12'd60; cmd_w_i = 12'd3; cmd_h_i = 12'd3;
    cmd_color_i = 16'hDEAD; cmd_mask_i = 4'h1; base_address_i = 24'h4000; cmd_valid_i = 1;
    chk("t5_ready_busy", cmd_ready_o, 0);
    @(posedge clk); #1 cmd_valid_i = 0;
    wait_done(11, "t5");

    push_rect(0, 0, 4, 4, 16'h5555, 4'hC, 24'h0);
    issue(0, 0, 4, 4, 16'h5555, 4'hC, 24'h0);
    repeat (4) @(negedge clk);
    #2 reset_n_i = 0;
    #1;
    chk("t6_rst_sel", vram_sel_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_done", done_o, 0);
    chk("t6_rst_ready", cmd_ready_o, 1);
    q.delete();
    @(posedge clk); #1 reset_n_i = 1;
    push_rect(5, 0, 3, 1, 16'h0042, 4'h3, 24'hFFFFFE);
    issue(5, 0, 3, 1, 16'h0042, 4'h3, 24'hFFFFFE);
    wait_done(6, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
